spwm_deadtime: RTL and testbench
================================

Name: spwm_deadtime

Overview:
- Sinusoidal PWM stage directly downstream of the NCO.
- Takes one signed NCO output sample (I or Q) per carrier period and compares it against a symmetric up/down triangular carrier.
- Drives one half-bridge leg as complementary high-side/low-side gate signals, with programmable dead time.
- One instance per bridge leg; legs are phase-aligned through the sync output.

Parameters:
DATA_BITS, 9, width of signed input sample (NCO LUT_DATA_BITS+1); carrier max M = 2**DATA_BITS-1
PRESC_BITS, 8, width of carrier prescaler input
DT_BITS, 8, width of dead-time input

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
en  input  1  leg enable; low forces outputs off and carrier to 0
sample  input  DATA_BITS  signed two's-complement modulation sample, sampled only at the carrier valley
prescale  input  PRESC_BITS  carrier advances once every prescale+1 clk cycles
dead_time  input  DT_BITS  dead time in clk cycles; 0 = no dead time
hs  output  1  high-side gate, active-high
ls  output  1  low-side gate, active-high
sync  output  1  one-cycle pulse when the carrier steps to 0 (duty reload)

Behaviour:
- Reset values: hs=0, ls=0, sync=0; carrier=0; direction=up; prescaler=0; duty=2**(DATA_BITS-1) (50%); FSM=IDLE; dead counter=0.
- Prescaler counts 0..prescale. A carrier step occurs when prescaler==prescale, and the prescaler then clears. A change of prescale takes effect at the next wrap.
- Carrier sequence, on steps only: 0,1,...,M,M-1,...,1,0,1,...
  - Direction flips at M and at 0.
  - Period is 2*M steps; 0 and M each occur once per period.
- Duty reload:
  - On the step that makes carrier 0, duty <= {~sample[MSB], sample[MSB-1:0]} (offset binary).
  - sync=1 on that same registered cycle.
  - A sample change at any other time has no effect until the next valley.
- Comparison: ref <= (duty > carrier), registered, re-evaluated every clk cycle.
- Leg FSM states: IDLE, HS_ON, LS_ON, DT_HS, DT_LS.
  - IDLE: hs=ls=0. With en=1 and ref=1, go to DT_HS with cnt=dead_time. With en=1 and ref=0, go to DT_LS. This gives a safe start.
  - HS_ON: hs=1. If ref=0, go to DT_LS with cnt=dead_time, and hs drops on the same transition.
  - LS_ON: ls=1. If ref=1, go to DT_HS, symmetric to HS_ON.
  - DT_x: hs=ls=0, cnt decrements.
    - If ref reverses during DT_x, switch to the opposite DT state and reload cnt=dead_time.
    - When cnt==0 and ref still matches, enter the x_ON state.
  - dead_time=0: DT_x lasts exactly one cycle with both outputs low. Minimum gap is 1 cycle.
- Outputs hs/ls are registered FSM outputs. Latency from a carrier step to an edge in the ON state is 2 cycles (ref register + output register) plus the dead time.
- Invariant: hs & ls is never 1, in any state, under any input or reset timing.
- en=0:
  - Next cycle: hs=ls=0, FSM=IDLE, carrier=0, direction=up, prescaler=0.
  - Duty is retained.
  - sync stays 0 while en=0.
- rst has priority over en and over fault. A mid-cycle reset drops hs/ls on the next edge.
- Sample extremes:
  - Most negative sample (-2**(DATA_BITS-1)) maps to duty 0, so ref is never 1 and the leg is LS_ON continuously.
  - Duty M gives ref=0 only at carrier M, so the pulse is narrower than the dead time and is absorbed by the DT restart rule.

Optional Feature:
- Macro: SPWM_FAULT_EN.
- Defined:
  - Adds input fault_n (active-low, asynchronous, passed through a 2-FF synchronizer), input fault_clr (1-cycle pulse), and output fault_latched.
  - A synchronized fault_n=0 sets fault_latched, forces hs=ls=0 and FSM=IDLE within 3 clk cycles of the fault_n falling edge. The carrier keeps running.
  - fault_clr clears the latch only when synchronized fault_n=1. Restart then proceeds through the IDLE→DT path.
  - Reset clears fault_latched.
- Not defined: the three ports are absent and there is no fault logic.

Test Plan:
- sample=0, prescale=0, dead_time=0, en=1: sync period 1022 cycles; hs high 510 and ls high 510 cycles per period; never hs&ls.
- Same with dead_time=10: every hs↔ls transition has exactly 11 both-low cycles; hs high 500 cycles per period.
- sample=+255, dead_time=10: ls never asserts; hs low for 12 cycles once per period, around carrier=511.
- sample=-128 applied at carrier=100 rising: hs high-time is unchanged until the next sync, then becomes 254 cycles per period.
- en deasserted while hs=1 → hs=0 next cycle. en reasserted → first hs/ls assertion only after dead_time+2 cycles; first sync 1022 cycles after en rises.
- SPWM_FAULT_EN: fault_n low while ls=1 → hs=ls=0 within 3 cycles and fault_latched=1. fault_clr with fault_n still low → latch held. fault_n high then fault_clr → outputs resume through dead time.

Source files
------------

// File: rtl/spwm_deadtime_if.sv
// rtl/spwm_deadtime_if.sv - control/gate bundle for one SPWM bridge leg; fault signals present under SPWM_FAULT_EN
interface spwm_deadtime_if #(
    parameter int DATA_BITS  = 9,
    parameter int PRESC_BITS = 8,
    parameter int DT_BITS    = 8
);
    logic                        en;
    logic signed [DATA_BITS-1:0] sample;
    logic [PRESC_BITS-1:0]       prescale;
    logic [DT_BITS-1:0]          dead_time;
    logic                        hs;
    logic                        ls;
    logic                        sync;
`ifdef SPWM_FAULT_EN
    logic                        fault_n;
    logic                        fault_clr;
    logic                        fault_latched;

    modport master (
        output en, sample, prescale, dead_time, fault_n, fault_clr,
        input  hs, ls, sync, fault_latched
    );
    modport slave (
        input  en, sample, prescale, dead_time, fault_n, fault_clr,
        output hs, ls, sync, fault_latched
    );
`else
    modport master (
        output en, sample, prescale, dead_time,
        input  hs, ls, sync
    );
    modport slave (
        input  en, sample, prescale, dead_time,
        output hs, ls, sync
    );
`endif
endinterface

// File: rtl/spwm_deadtime.sv
// rtl/spwm_deadtime.sv - triangular-carrier SPWM leg with complementary dead-time gates
// Optional fault latch and gate shutdown when SPWM_FAULT_EN is defined.
module spwm_deadtime #(
    parameter int DATA_BITS  = 9,
    parameter int PRESC_BITS = 8,
    parameter int DT_BITS    = 8
) (
    input logic            clk,
    input logic            rst,
    spwm_deadtime_if.slave bus
);
    localparam int MSB = DATA_BITS - 1;
    localparam logic [DATA_BITS-1:0]  CAR_MAX   = '1;
    localparam logic [DATA_BITS-1:0]  CAR_TOP   = {{(DATA_BITS-1){1'b1}}, 1'b0};
    localparam logic [DATA_BITS-1:0]  CAR_ONE   = {{(DATA_BITS-1){1'b0}}, 1'b1};
    localparam logic [DATA_BITS-1:0]  DUTY_HALF = {1'b1, {(DATA_BITS-1){1'b0}}};
    localparam logic [PRESC_BITS-1:0] PRESC_ONE = {{(PRESC_BITS-1){1'b0}}, 1'b1};
    localparam logic [DT_BITS-1:0]    CNT_ONE   = {{(DT_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, HS_ON, LS_ON, DT_HS, DT_LS} state_t;

    state_t                 state_q, state_d;
    logic [DT_BITS-1:0]     cnt_q, cnt_d;
    logic [PRESC_BITS-1:0]  presc_q, presc_d;
    logic [DATA_BITS-1:0]   carrier_q, carrier_d;
    logic [DATA_BITS-1:0]   duty_q, duty_d;
    logic                   dir_up_q, dir_up_d;
    logic                   sync_q, sync_d;
    logic                   ref_q, ref_d;
    logic                   hs_q, hs_d;
    logic                   ls_q, ls_d;
    logic                   step;
    logic                   fault_hold;

`ifdef SPWM_FAULT_EN
    logic fault_s1_q, fault_s2_q, fault_latched_q;

    // Gates stay off while the synchronized fault is active or the latch is still set.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_s1_q      <= 1'b1;
            fault_s2_q      <= 1'b1;
            fault_latched_q <= 1'b0;
        end else begin
            fault_s1_q <= bus.fault_n;
            fault_s2_q <= fault_s1_q;
            if (!fault_s2_q)
                fault_latched_q <= 1'b1;
            else if (bus.fault_clr)
                fault_latched_q <= 1'b0;
        end
    end

    assign fault_hold        = !fault_s2_q || fault_latched_q;
    assign bus.fault_latched = fault_latched_q;
`else
    assign fault_hold = 1'b0;
`endif

    always_comb begin
        step      = (presc_q >= bus.prescale);
        presc_d   = step ? '0 : presc_q + PRESC_ONE;
        carrier_d = carrier_q;
        dir_up_d  = dir_up_q;
        duty_d    = duty_q;
        sync_d    = 1'b0;
        if (!bus.en) begin
            presc_d   = '0;
            carrier_d = '0;
            dir_up_d  = 1'b1;
        end else if (step) begin
            if (dir_up_q) begin
                carrier_d = carrier_q + CAR_ONE;
                if (carrier_q == CAR_TOP)
                    dir_up_d = 1'b0;
            end else begin
                carrier_d = carrier_q - CAR_ONE;
                if (carrier_q == CAR_ONE) begin
                    // Valley: reload duty as offset binary so the signed sample maps onto 0..CAR_MAX.
                    dir_up_d = 1'b1;
                    sync_d   = 1'b1;
                    duty_d   = {~bus.sample[MSB], bus.sample[MSB-1:0]};
                end
            end
        end
        ref_d = (duty_q > carrier_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d = ref_q ? DT_HS : DT_LS;
                    cnt_d   = bus.dead_time;
                end
            end
            HS_ON: begin
                if (!ref_q) begin
                    state_d = DT_LS;
                    cnt_d   = bus.dead_time;
                end
            end
            LS_ON: begin
                if (ref_q) begin
                    state_d = DT_HS;
                    cnt_d   = bus.dead_time;
                end
            end
            DT_HS: begin
                if (!ref_q) begin
                    state_d = DT_LS;
                    cnt_d   = bus.dead_time;
                end else if (cnt_q == '0) begin
                    state_d = HS_ON;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DT_LS: begin
                if (ref_q) begin
                    state_d = DT_HS;
                    cnt_d   = bus.dead_time;
                end else if (cnt_q == '0) begin
                    state_d = LS_ON;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!bus.en || fault_hold) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
        // Gates decode the next state, so both can never be high together.
        hs_d = (state_d == HS_ON);
        ls_d = (state_d == LS_ON);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            presc_q   <= '0;
            carrier_q <= '0;
            duty_q    <= DUTY_HALF;
            dir_up_q  <= 1'b1;
            sync_q    <= 1'b0;
            ref_q     <= 1'b0;
            hs_q      <= 1'b0;
            ls_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            carrier_q <= carrier_d;
            duty_q    <= duty_d;
            dir_up_q  <= dir_up_d;
            sync_q    <= sync_d;
            ref_q     <= ref_d;
            hs_q      <= hs_d;
            ls_q      <= ls_d;
        end
    end

    assign bus.hs   = hs_q;
    assign bus.ls   = ls_q;
    assign bus.sync = sync_q;

endmodule

// File: tb/tb_spwm_deadtime.sv
// tb/tb_spwm_deadtime.sv - self-checking bench for spwm_deadtime with per-period scoreboard
module tb_spwm_deadtime;
    localparam int DB  = 9;
    localparam int PB  = 8;
    localparam int DTB = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spwm_deadtime_if #(.DATA_BITS(DB), .PRESC_BITS(PB), .DT_BITS(DTB)) dif ();
    spwm_deadtime #(.DATA_BITS(DB), .PRESC_BITS(PB), .DT_BITS(DTB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    typedef struct {
        string name;
        int    period;
        int    hs;
        int    ls;
        int    ngap;
        int    gap;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   overlap_seen = 1'b0;

    always @(negedge clk) if (dif.hs && dif.ls) overlap_seen <= 1'b1;

    task automatic push_exp(input string n, input int p, input int h, input int l, input int ng, input int g);
        exp_t e;
        e.name = n; e.period = p; e.hs = h; e.ls = l; e.ngap = ng; e.gap = g;
        sb_q.push_back(e);
    endtask

    task automatic configure(input logic signed [DB-1:0] s, input int dt, input int ps);
        @(negedge clk);
        dif.sample    = s;
        dif.dead_time = dt[DTB-1:0];
        dif.prescale  = ps[PB-1:0];
    endtask

    task automatic wait_sync(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (dif.sync) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) $display("FAIL sync_timeout: got no sync, expected sync within 5000 cycles");
        else passed++;
    endtask

    // Called on a cycle showing sync=1; counts one carrier period up to the next sync.
    task automatic measure(input int chg_at, input logic signed [DB-1:0] chg_val);
        exp_t e;
        int per = 0, nhs = 0, nls = 0, ng = 0, run = 0;
        int gmin = 1000000, gmax = 0;
        e = sb_q.pop_front();
        do begin
            if (per == chg_at) dif.sample = chg_val;
            if (dif.hs) nhs++;
            if (dif.ls) nls++;
            if (dif.hs || dif.ls) begin
                if (run > 0) begin
                    ng++;
                    if (run < gmin) gmin = run;
                    if (run > gmax) gmax = run;
                end
                run = 0;
            end else begin
                run++;
            end
            per++;
            @(negedge clk);
        end while (!dif.sync && per < 5000);
        checks++;
        if (per !== e.period) $display("FAIL %s period: got %0d expected %0d", e.name, per, e.period);
        else passed++;
        checks++;
        if (nhs !== e.hs) $display("FAIL %s hs_high: got %0d expected %0d", e.name, nhs, e.hs);
        else passed++;
        checks++;
        if (nls !== e.ls) $display("FAIL %s ls_high: got %0d expected %0d", e.name, nls, e.ls);
        else passed++;
        checks++;
        if (ng !== e.ngap) $display("FAIL %s gap_count: got %0d expected %0d", e.name, ng, e.ngap);
        else passed++;
        if (e.ngap > 0) begin
            checks++;
            if (gmin !== e.gap || gmax !== e.gap)
                $display("FAIL %s gap_len: got min %0d max %0d expected %0d", e.name, gmin, gmax, e.gap);
            else passed++;
        end
    endtask

    task automatic scenario(input string n, input logic signed [DB-1:0] s, input int dt, input int ps,
                            input int p, input int h, input int l, input int ng, input int g);
        bit ok;
        configure(s, dt, ps);
        push_exp(n, p, h, l, ng, g);
        wait_sync(ok);
        wait_sync(ok);
        measure(-1, s);
    endtask

    task automatic test_reset();
        int first = 0;
        rst = 1'b1;
        dif.en = 1'b1;
        dif.sample = '0;
        dif.dead_time = '0;
        dif.prescale = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (dif.hs !== 1'b0) $display("FAIL reset_hs: got %b expected 0", dif.hs); else passed++;
        checks++;
        if (dif.ls !== 1'b0) $display("FAIL reset_ls: got %b expected 0", dif.ls); else passed++;
        checks++;
        if (dif.sync !== 1'b0) $display("FAIL reset_sync: got %b expected 0", dif.sync); else passed++;
`ifdef SPWM_FAULT_EN
        checks++;
        if (dif.fault_latched !== 1'b0) $display("FAIL reset_fault_latched: got %b expected 0", dif.fault_latched);
        else passed++;
`endif
        rst = 1'b0;
        for (int k = 1; k <= 1100 && first == 0; k++) begin
            @(negedge clk);
            if (dif.sync) first = k;
        end
        checks++;
        if (first !== 1022) $display("FAIL reset_first_sync: got %0d expected 1022", first); else passed++;
    endtask

    task automatic test_sample_change();
        bit ok;
        configure('0, 0, 0);
        push_exp("before_reload", 1022, 510, 510, 2, 1);
        push_exp("after_reload", 1022, 254, 766, 2, 1);
        wait_sync(ok);
        wait_sync(ok);
        measure(100, 9'h180);
        measure(-1, 9'h180);
    endtask

    task automatic test_reset_mid();
        bit ok;
        configure('0, 0, 0);
        wait_sync(ok);
        wait_sync(ok);
        checks++;
        if (dif.hs !== 1'b1) $display("FAIL mid_reset_pre_hs: got %b expected 1", dif.hs); else passed++;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dif.hs !== 1'b0 || dif.ls !== 1'b0)
            $display("FAIL mid_reset_gates: got hs=%b ls=%b expected 0 0", dif.hs, dif.ls);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_enable();
        bit ok, bad = 1'b0, early = 1'b0;
        logic hs_at = 1'b0;
        int first = 0;
        configure('0, 10, 0);
        wait_sync(ok);
        wait_sync(ok);
        checks++;
        if (dif.hs !== 1'b1) $display("FAIL en_pre_hs: got %b expected 1", dif.hs); else passed++;
        dif.en = 1'b0;
        @(negedge clk);
        checks++;
        if (dif.hs !== 1'b0 || dif.ls !== 1'b0)
            $display("FAIL en_off_gates: got hs=%b ls=%b expected 0 0", dif.hs, dif.ls);
        else passed++;
        repeat (40) begin
            @(negedge clk);
            if (dif.hs || dif.ls || dif.sync) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) $display("FAIL en_off_quiet: got activity=%b expected 0", bad); else passed++;
        dif.en = 1'b1;
        for (int k = 1; k <= 1030; k++) begin
            @(negedge clk);
            if (k <= 11 && (dif.hs || dif.ls)) early = 1'b1;
            if (k == 12) hs_at = dif.hs;
            if (dif.sync && first == 0) first = k;
        end
        checks++;
        if (early !== 1'b0) $display("FAIL en_early_gate: got %b expected 0", early); else passed++;
        checks++;
        if (hs_at !== 1'b1) $display("FAIL en_first_hs: got %b expected 1", hs_at); else passed++;
        checks++;
        if (first !== 1022) $display("FAIL en_first_sync: got %0d expected 1022", first); else passed++;
    endtask

`ifdef SPWM_FAULT_EN
    task automatic test_fault();
        bit found = 1'b0, early = 1'b0;
        logic on_at = 1'b0;
        configure('0, 3, 0);
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (dif.ls) found = 1'b1;
        end
        checks++;
        if (!found) $display("FAIL fault_pre_ls: got no ls, expected ls within 3000 cycles"); else passed++;
        dif.fault_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dif.hs !== 1'b0 || dif.ls !== 1'b0 || dif.fault_latched !== 1'b1)
            $display("FAIL fault_trip: got hs=%b ls=%b latched=%b expected 0 0 1", dif.hs, dif.ls, dif.fault_latched);
        else passed++;
        dif.fault_clr = 1'b1;
        @(negedge clk);
        dif.fault_clr = 1'b0;
        checks++;
        if (dif.fault_latched !== 1'b1 || dif.hs !== 1'b0 || dif.ls !== 1'b0)
            $display("FAIL fault_clr_held: got latched=%b hs=%b ls=%b expected 1 0 0", dif.fault_latched, dif.hs, dif.ls);
        else passed++;
        dif.fault_n = 1'b1;
        repeat (4) @(negedge clk);
        dif.fault_clr = 1'b1;
        @(negedge clk);
        dif.fault_clr = 1'b0;
        checks++;
        if (dif.fault_latched !== 1'b0) $display("FAIL fault_clr: got latched=%b expected 0", dif.fault_latched);
        else passed++;
        if (dif.hs || dif.ls) early = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j <= 4 && (dif.hs || dif.ls)) early = 1'b1;
            if (j == 5) on_at = dif.hs | dif.ls;
        end
        checks++;
        if (early !== 1'b0) $display("FAIL fault_restart_early: got %b expected 0", early); else passed++;
        checks++;
        if (on_at !== 1'b1) $display("FAIL fault_restart_on: got %b expected 1", on_at); else passed++;
    endtask
`endif

    initial begin
`ifdef SPWM_FAULT_EN
        dif.fault_n = 1'b1;
        dif.fault_clr = 1'b0;
`endif
        test_reset();
        scenario("mid_duty_dt0", '0, 0, 0, 1022, 510, 510, 2, 1);
        scenario("mid_duty_dt10", '0, 10, 0, 1022, 500, 500, 2, 11);
        scenario("full_scale_dt10", 9'sd255, 10, 0, 1022, 1010, 0, 1, 12);
        test_sample_change();
        scenario("neg_extreme", 9'h100, 5, 0, 1022, 0, 1022, 0, 0);
        scenario("prescale1", '0, 0, 1, 2044, 1021, 1021, 2, 1);
        test_reset_mid();
        test_enable();
`ifdef SPWM_FAULT_EN
        test_fault();
`endif
        checks++;
        if (overlap_seen !== 1'b0) $display("FAIL overlap: got hs&ls seen=%b expected 0", overlap_seen);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
